inport_ctrl: RTL and testbench
==============================

# inport_ctrl

Input-port front end for the MIPS memory-mapped I/O subsystem. It synchronizes the board switches and one active-low load push-button, and debounces the button with a counter-based state machine. For each debounced press it emits a single-cycle write enable to either input-port register (address 0xFFF8 or 0xFFFC in the memory block). It drives the memory block's `in_data`, `inport_0_en` and `inport_1_en` inputs directly.

## Interface

- `WIDTH`, 32: data width of `in_data`; must match the memory block.
- `DATA_BITS`, 9: number of switch bits carried as data (`switches[DATA_BITS-1:0]`).
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronized samples required to accept a press or release; legal range 2..2^20.
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst`  input  1  reset, asynchronous, active-low; asserting it forces all state to reset values immediately.
- `switches`  input  DATA_BITS+1  raw board switches; `[DATA_BITS-1:0]` are data, `[DATA_BITS]` is the port select (0 = inport 0, 1 = inport 1).
- `button_n`  input  1  raw load push-button, active-low, asynchronous, bouncy.
- `in_data`  output  WIDTH  zero-extended synchronized switch data.
- `inport_0_en`  output  1  one-cycle load pulse for inport 0.
- `inport_1_en`  output  1  one-cycle load pulse for inport 1.
- `busy`  output  1  high whenever the button FSM is not in IDLE.

## Operation

- **Synchronizers:** `switches` and `button_n` each pass through a 2-flop synchronizer. The reset value of the button synchronizer is 1 (released); the switch synchronizer resets to 0.
- **`in_data`:** `{(WIDTH-DATA_BITS)'b0, sw_sync[DATA_BITS-1:0]}`, taken from the synchronizer output flops. No debounce is applied to switches; they are only sampled on a pulse.
- **Button FSM**, with counter `cnt` sized `$clog2(DEBOUNCE_CYCLES)+1`:
  - **IDLE:** `cnt=0`. Synced button low → PRESS_WAIT with `cnt=1`.
  - **PRESS_WAIT:**
    - Synced low → `cnt` increments.
    - Synced high → IDLE with `cnt=0` (glitch rejected, no pulse).
    - When `cnt==DEBOUNCE_CYCLES` and synced is still low → HELD and `cnt=0`. The pulse is asserted in the first HELD cycle.
  - **HELD:** synced high → RELEASE_WAIT with `cnt=1`. Otherwise stay; no further pulses however long the button is held.
  - **RELEASE_WAIT:**
    - Synced high → `cnt` increments.
    - Synced low → HELD with `cnt=0` (release bounce, no pulse).
    - When `cnt==DEBOUNCE_CYCLES` and synced is still high → IDLE.
- **Pulse:** `inport_0_en` or `inport_1_en` is high for exactly one cycle, on the cycle the FSM enters HELD.
  - The select is `sw_sync[DATA_BITS]`, sampled in that same cycle.
  - Exactly one enable is high per accepted press; both enables are never high together.
  - `in_data` is valid in the pulse cycle, so the downstream register captures the switch value present at that edge.
- Pulse and enable outputs are registered, so there are no combinational paths from inputs to outputs.
- A select or data switch change during HELD or RELEASE_WAIT has no effect until the next accepted press.

## Timing

- **Reset values:**
  - FSM IDLE, `cnt=0`.
  - `in_data=0`, `inport_0_en=0`, `inport_1_en=0`, `busy=0`.
  - Switch synchronizer 0; button synchronizer 1.
- **Press latency:** raw `button_n` goes low and stays low before rising edge k. Synced low is visible after edge k+1, which enters PRESS_WAIT at edge k+2. The enable pulse is high in the cycle following edge k+2+DEBOUNCE_CYCLES.
- **Glitch rejection:** a low pulse shorter than DEBOUNCE_CYCLES synced samples produces no enable and returns `busy` to 0.
- **Re-arm:** a new press is accepted only after the release has been stable for DEBOUNCE_CYCLES samples. The minimum spacing between two enable pulses is therefore 2·DEBOUNCE_CYCLES+2 cycles.
- **Switch latency:** a switch change is reflected on `in_data` 2 cycles later.
- **Reset mid-operation:**
  - Asserting `rst` in any state clears outputs asynchronously; no pulse is emitted.
  - After deassertion, a button still held low is treated as a fresh press: the full debounce applies and a pulse is emitted.
- **Counter:** saturation is never reached; `cnt` never exceeds DEBOUNCE_CYCLES.

## Test plan

- **Reset check:** with `rst=0`, drive `button_n=0` and `switches=10'h3FF`. Required: all outputs 0 and `busy=0`. Release reset and hold the button. Required: exactly one `inport_1_en` pulse with `in_data=32'h000001FF`, DEBOUNCE_CYCLES+3 cycles after the first post-reset edge.
- **Clean press to inport 0:**
  - Stimulus: `switches=10'h0A5`, `button_n` low for 100 cycles, then high for 100 cycles (DEBOUNCE_CYCLES=16).
  - Required: one `inport_0_en` pulse at the specified latency with `in_data=32'h000000A5`, `inport_1_en` never high, and `busy` back to 0 after the release debounce.
- **Bouncy press:**
  - Stimulus: `button_n` toggles every 3 cycles for 30 cycles, then stays low for 40 cycles. Press bounce and release bounce are repeated identically.
  - Required: exactly one pulse total.
- **Short glitch:** `button_n` low for 10 cycles, then high. Required: no enable pulse, `busy` returns to 0.
- **Select change while held:**
  - Stimulus: press with `switches[9]=0`, flip `switches[9]` to 1 and the data to 0x1FF during HELD, then release.
  - Required: one `inport_0_en` pulse only, carrying the pre-flip data.
  - Then press again. Required: one `inport_1_en` pulse with `in_data=32'h1FF`.
- **Reset mid-debounce:** assert `rst` at `cnt=8` in PRESS_WAIT. Required: `busy=0` immediately and no pulse during reset.

Source files
------------

// File: rtl/inport_ctrl.sv
// Input-port front end: synchronizes board switches and the load button, debounces
// the button and issues one registered write enable per accepted press.
module inport_ctrl #(
  parameter int WIDTH           = 32,
  parameter int DATA_BITS       = 9,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS:0]   switches,
  input  logic                 button_n,
  output logic [WIDTH-1:0]     in_data,
  output logic                 inport_0_en,
  output logic                 inport_1_en,
  output logic                 busy
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS:0]   sw_meta_q, sw_meta_d;
  logic [DATA_BITS:0]   sw_sync_q, sw_sync_d;
  logic                 btn_meta_q, btn_meta_d;
  logic                 btn_sync_q, btn_sync_d;
  logic                 en0_q, en0_d;
  logic                 en1_q, en1_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    en0_d      = 1'b0;
    en1_d      = 1'b0;
    sw_meta_d  = switches;
    sw_sync_d  = sw_meta_q;
    btn_meta_d = button_n;
    btn_sync_d = btn_meta_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!btn_sync_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (btn_sync_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          // The enable is registered so it lands in the first HELD cycle
          state_d = HELD;
          cnt_d   = '0;
          en1_d   = sw_sync_q[DATA_BITS];
          en0_d   = ~sw_sync_q[DATA_BITS];
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        cnt_d = '0;
        if (btn_sync_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (!btn_sync_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Button synchronizer resets to released so reset never looks like a press
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= 1'b1;
      btn_sync_q <= 1'b1;
      en0_q      <= 1'b0;
      en1_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
      en0_q      <= en0_d;
      en1_q      <= en1_d;
    end
  end

  assign in_data     = {{(WIDTH-DATA_BITS){1'b0}}, sw_sync_q[DATA_BITS-1:0]};
  assign inport_0_en = en0_q;
  assign inport_1_en = en1_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_inport_ctrl.sv
// Self-checking bench for inport_ctrl: directed segment table, reset sequences and
// randomized button/switch activity compared against a run-length debounce model.
module tb_inport_ctrl;

  localparam int WIDTH     = 32;
  localparam int DATA_BITS = 9;
  localparam int DEB       = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              button_n = 1'b1;
  logic [DATA_BITS:0] switches = '0;
  logic [WIDTH-1:0]  in_data;
  logic              inport_0_en;
  logic              inport_1_en;
  logic              busy;

  int checks = 0;
  int errors = 0;

  inport_ctrl #(
    .WIDTH(WIDTH),
    .DATA_BITS(DATA_BITS),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .switches(switches),
    .button_n(button_n),
    .in_data(in_data),
    .inport_0_en(inport_0_en),
    .inport_1_en(inport_1_en),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples delayed two edges, then a debounced level that
  // flips after DEB+1 consecutive opposite-level samples; a pulse on press only.
  logic        rawBtn[$];
  logic [9:0]  rawSw[$];
  logic        modelPressed;
  int          modelRun;
  logic        exp0, exp1;

  int          seg0, seg1;
  logic [31:0] segData;

  task automatic modelReset();
    rawBtn       = '{1'b1, 1'b1};
    rawSw        = '{10'h000, 10'h000};
    modelPressed = 1'b0;
    modelRun     = 0;
    exp0         = 1'b0;
    exp1         = 1'b0;
  endtask

  task automatic modelEdge(input logic b, input logic [9:0] s);
    logic       syncB;
    logic [9:0] syncS;
    syncB = rawBtn[0];
    syncS = rawSw[0];
    exp0  = 1'b0;
    exp1  = 1'b0;
    if (syncB == modelPressed) begin
      modelRun++;
      if (modelRun == DEB + 1) begin
        if (!modelPressed) begin
          exp1 = syncS[9];
          exp0 = ~syncS[9];
        end
        modelPressed = ~modelPressed;
        modelRun     = 0;
      end
    end else begin
      modelRun = 0;
    end
    void'(rawBtn.pop_front());
    rawBtn.push_back(b);
    void'(rawSw.pop_front());
    rawSw.push_back(s);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput();
    logic [31:0] expData;
    logic        expBusy;
    expData = {22'b0, rawSw[0][8:0]};
    expBusy = modelPressed || (modelRun != 0);
    check("in_data", in_data, expData);
    check("inport_0_en", {31'b0, inport_0_en}, {31'b0, exp0});
    check("inport_1_en", {31'b0, inport_1_en}, {31'b0, exp1});
    check("busy", {31'b0, busy}, {31'b0, expBusy});
    if (inport_0_en) seg0++;
    if (inport_1_en) seg1++;
    if (inport_0_en || inport_1_en) segData = in_data;
  endtask

  task automatic applyStimulus(input logic b, input logic [9:0] s);
    button_n = b;
    switches = s;
    @(posedge clk);
    if (!rst) modelReset();
    else      modelEdge(b, s);
    #1;
    checkOutput();
  endtask

  task automatic assertReset();
    rst = 1'b0;
    #1;
    modelReset();
    checkOutput();
  endtask

  // Holds the button after reset release and checks the single pulse latency
  task automatic pressAfterReset(input logic [9:0] s, input string name);
    int firstAt;
    firstAt = -1;
    seg0 = 0; seg1 = 0; segData = '0;
    rst = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      applyStimulus(1'b0, s);
      if ((inport_0_en || inport_1_en) && firstAt < 0) firstAt = n;
    end
    check({name, " latency"}, firstAt, DEB + 3);
    check({name, " pulses0"}, seg0, {31'b0, ~s[9]});
    check({name, " pulses1"}, seg1, {31'b0, s[9]});
    check({name, " data"}, segData, {23'b0, s[8:0]});
    for (int n = 0; n < 40; n++) applyStimulus(1'b1, s);
    check({name, " busy after release"}, {31'b0, busy}, 32'd0);
  endtask

  typedef struct {
    logic        btn;
    logic [9:0]  sw;
    int          cycles;
    int          exp0;
    int          exp1;
    logic [31:0] expData;
    logic        expBusyEnd;
  } seg_t;

  seg_t table_q[$];

  function automatic seg_t mk(input logic b, input logic [9:0] s, input int c,
                              input int e0, input int e1, input logic [31:0] d,
                              input logic be);
    seg_t r;
    r.btn = b; r.sw = s; r.cycles = c; r.exp0 = e0; r.exp1 = e1;
    r.expData = d; r.expBusyEnd = be;
    return r;
  endfunction

  initial begin
    modelReset();

    // Reset held with button pressed and all switches on
    button_n = 1'b0;
    switches = 10'h3FF;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 10'h3FF);
    pressAfterReset(10'h3FF, "reset press");

    table_q.push_back(mk(1'b0, 10'h0A5, 100, 1, 0, 32'h0A5, 1'b1));
    table_q.push_back(mk(1'b1, 10'h0A5, 100, 0, 0, 32'h0,   1'b0));
    for (int i = 0; i < 10; i++)
      table_q.push_back(mk(logic'(i % 2), 10'h055, 3, 0, 0, 32'h0, logic'(i % 2 == 0)));
    table_q.push_back(mk(1'b0, 10'h055, 40, 1, 0, 32'h055, 1'b1));
    for (int i = 0; i < 10; i++)
      table_q.push_back(mk(logic'(i % 2 == 0), 10'h055, 3, 0, 0, 32'h0, 1'b1));
    table_q.push_back(mk(1'b1, 10'h055, 40, 0, 0, 32'h0,   1'b0));
    table_q.push_back(mk(1'b0, 10'h055, 10, 0, 0, 32'h0,   1'b1));
    table_q.push_back(mk(1'b1, 10'h055, 30, 0, 0, 32'h0,   1'b0));
    table_q.push_back(mk(1'b0, 10'h012, 40, 1, 0, 32'h012, 1'b1));
    table_q.push_back(mk(1'b0, 10'h3FF, 20, 0, 0, 32'h0,   1'b1));
    table_q.push_back(mk(1'b1, 10'h3FF, 40, 0, 0, 32'h0,   1'b0));
    table_q.push_back(mk(1'b0, 10'h3FF, 40, 0, 1, 32'h1FF, 1'b1));
    table_q.push_back(mk(1'b1, 10'h3FF, 40, 0, 0, 32'h0,   1'b0));

    foreach (table_q[i]) begin
      seg0 = 0; seg1 = 0; segData = '0;
      for (int c = 0; c < table_q[i].cycles; c++)
        applyStimulus(table_q[i].btn, table_q[i].sw);
      check($sformatf("row%0d pulses0", i), seg0, table_q[i].exp0);
      check($sformatf("row%0d pulses1", i), seg1, table_q[i].exp1);
      if (table_q[i].exp0 + table_q[i].exp1 > 0)
        check($sformatf("row%0d data", i), segData, table_q[i].expData);
      check($sformatf("row%0d busy", i), {31'b0, busy}, {31'b0, table_q[i].expBusyEnd});
    end

    // Reset in the middle of the press debounce, button kept low throughout
    seg0 = 0; seg1 = 0;
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 10'h0AA);
    check("mid-debounce busy before reset", {31'b0, busy}, 32'd1);
    assertReset();
    check("mid-debounce busy in reset", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 10'h0AA);
    check("mid-debounce pulses in reset", seg0 + seg1, 0);
    pressAfterReset(10'h0AA, "post-reset press");

    // Random bouncy activity with occasional asynchronous resets
    for (int s = 0; s < 150; s++) begin
      logic       b;
      logic [9:0] sw;
      int         len;
      b   = logic'($urandom_range(0, 1));
      sw  = 10'($urandom);
      len = $urandom_range(1, 24);
      for (int c = 0; c < len; c++) applyStimulus(b, sw);
      if ($urandom_range(0, 39) == 0) begin
        assertReset();
        for (int c = 0; c < int'($urandom_range(1, 3)); c++) applyStimulus(b, sw);
        rst = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
